phaser_out_mc_ctrl: RTL and testbench
=====================================

PHASER_OUT_MC_CTRL -- requirements
Module: phaser_out_mc_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent output-phase channels (1..8).
REQ-002 Parameter CLKOUT_DIV, default 4, divider ratio for OCLKDIVEN (2..16); other values SHALL stop elaboration with an error.
REQ-003 Parameter FINE_DELAY, default 0, reset fine tap (0..63); COARSE_DELAY, default 0, reset coarse tap (0..7).
REQ-004 Parameter SETTLE_CYC, default 4, busy cycles after any tap change (1..15); RST_HOLD_DIV, default 2, OCLKDIVEN periods OSERDESRST stays high after reset (1..7).
REQ-005 Parameter SYNC_IN_DIV_RST, default "FALSE"; "TRUE" enables divider realignment on SYNCIN.
REQ-006 SYSCLK  in  1  sole clock; all logic on rising edge.
REQ-007 RST  in  1  reset, synchronous and active-high.
REQ-008 SYNCIN  in  1  divider realignment request, synchronous to SYSCLK.
REQ-009 CHSEL  in  clog2(NUM_CH) (min 1)  channel addressed by all adjust/load/read inputs.
REQ-010 FINEENABLE, FINEINC, COARSEENABLE, COARSEINC  in  1 each  single-cycle step request and direction (1=inc, 0=dec).
REQ-011 COUNTERLOADEN  in  1, COUNTERLOADVAL  in  9  load request; [8:6] coarse, [5:0] fine.
REQ-012 COUNTERREADEN  in  1  read request for CHSEL.
REQ-013 COUNTERREADVAL  out  9, COUNTERREADVALID  out  1  read data {coarse,fine} and 1-cycle valid.
REQ-014 FINEOVERFLOW, COARSEOVERFLOW  out  NUM_CH each  per-channel saturation pulses.
REQ-015 BUSY  out  NUM_CH  channel settling; TAPS  out  9*NUM_CH  live {coarse,fine} per channel, ch0 in LSBs.
REQ-016 OCLKDIVEN  out  1  divided-clock enable; OSERDESRST  out  1  serializer reset.

Function
REQ-017 Requests on a channel with BUSY=1 SHALL be ignored except COUNTERREADEN.
REQ-018 Priority per cycle on CHSEL: load > {fine, coarse}; fine and coarse together SHALL both apply; load SHALL discard simultaneous steps.
REQ-019 Step/load SHALL update TAPS on the next edge (latency 1) and set BUSY for exactly SETTLE_CYC cycles starting that edge.
REQ-020 Fine inc at 63 or dec at 0 SHALL leave tap unchanged, pulse FINEOVERFLOW[ch] one cycle, and SHALL NOT set BUSY; coarse likewise at 7/0 with COARSEOVERFLOW.
REQ-021 No wrap-around: taps saturate; load takes any 9-bit value verbatim.
REQ-022 COUNTERREADEN SHALL return TAPS of CHSEL as sampled that cycle (pre-update) one cycle later with COUNTERREADVALID; COUNTERREADVAL holds until next read.
REQ-023 Divider counter 0..CLKOUT_DIV-1, free-running; OCLKDIVEN=1 in cycles where count==0.
REQ-024 With SYNC_IN_DIV_RST="TRUE", a SYNCIN rising edge (registered previous vs current) SHALL force count to 0 on the next edge; level-high SYNCIN SHALL not retrigger; "FALSE" ignores SYNCIN.
REQ-025 OSERDESRST SHALL deassert in the cycle after the RST_HOLD_DIV-th OCLKDIVEN following reset release, aligned so first low cycle has count==1.
REQ-026 SYNCIN realignment SHALL NOT reassert OSERDESRST.

Reset
REQ-027 RST SHALL set: fine=FINE_DELAY, coarse=COARSE_DELAY all channels; BUSY=0; overflow=0; COUNTERREADVAL=0; COUNTERREADVALID=0; divider count=0; OCLKDIVEN=0; OSERDESRST=1.
REQ-028 RST mid-settle or mid-read SHALL abort the operation; no pending pulse emerges after release.

Structure
REQ-029 Shared package holds tap widths (6 fine, 3 coarse, 9 counter), max values, and parameter-range check constants.
REQ-030 One sub-module phaser_tap_chan (tap registers, saturation, settle counter), instantiated NUM_CH times; divider and OSERDESRST logic stay top-level.

Verification
REQ-031 Reset, FINE_DELAY=5: TAPS ch0=0x005; after 2nd OCLKDIVEN (DIV=4, HOLD=2) OSERDESRST falls -> low at cycle 9 after release.
REQ-032 CHSEL=1, FINEINC pulse ×3 spaced 5 cycles -> ch1 fine 0->3, BUSY 4 cycles each; pulse during BUSY -> no change.
REQ-033 Load ch2 0x1FF, then FINEINC -> tap stays 0x1FF, FINEOVERFLOW[2] one cycle, BUSY[2] stays 0.
REQ-034 Same cycle load 0x040 and FINEENABLE on ch0 -> tap=0x040 exactly.
REQ-035 SYNC_IN_DIV_RST="TRUE", SYNCIN rises at count==2 and held high 10 cycles -> OCLKDIVEN next cycle, then every 4 cycles, no extra realignment.
REQ-036 Read ch3 same cycle as its COARSEINC -> COUNTERREADVAL shows pre-increment value, COUNTERREADVALID one cycle.

Source files
------------

// File: rtl/phaser_out_mc_ctrl_pkg.sv
// phaser_out_mc_ctrl_pkg: shared tap widths, tap limits and parameter ranges
package phaser_out_mc_ctrl_pkg;
  localparam int FINE_W = 6;
  localparam int COARSE_W = 3;
  localparam int CNT_W = 9;
  localparam logic [FINE_W-1:0] FINE_MAX = '1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = '1;
  localparam int NUM_CH_MIN = 1;
  localparam int NUM_CH_MAX = 8;
  localparam int DIV_MIN = 2;
  localparam int DIV_MAX = 16;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 7;
  function automatic int chsel_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/phaser_out_mc_ctrl_if.sv
// phaser_out_mc_ctrl_if: tap adjust/read bus and divider outputs
interface phaser_out_mc_ctrl_if
  import phaser_out_mc_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) ();
  localparam int CW = chsel_w(NUM_CH);
  logic SYNCIN;
  logic [CW-1:0] CHSEL;
  logic FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
  logic COUNTERLOADEN;
  logic [CNT_W-1:0] COUNTERLOADVAL;
  logic COUNTERREADEN;
  logic [CNT_W-1:0] COUNTERREADVAL;
  logic COUNTERREADVALID;
  logic [NUM_CH-1:0] FINEOVERFLOW, COARSEOVERFLOW, BUSY;
  logic [CNT_W*NUM_CH-1:0] TAPS;
  logic OCLKDIVEN, OSERDESRST;
  modport master (
    output SYNCIN, CHSEL, FINEENABLE, FINEINC, COARSEENABLE, COARSEINC,
           COUNTERLOADEN, COUNTERLOADVAL, COUNTERREADEN,
    input  COUNTERREADVAL, COUNTERREADVALID, FINEOVERFLOW, COARSEOVERFLOW,
           BUSY, TAPS, OCLKDIVEN, OSERDESRST
  );
  modport slave (
    input  SYNCIN, CHSEL, FINEENABLE, FINEINC, COARSEENABLE, COARSEINC,
           COUNTERLOADEN, COUNTERLOADVAL, COUNTERREADEN,
    output COUNTERREADVAL, COUNTERREADVALID, FINEOVERFLOW, COARSEOVERFLOW,
           BUSY, TAPS, OCLKDIVEN, OSERDESRST
  );
endinterface

// File: rtl/phaser_out_mc_ctrl_tap_chan.sv
// phaser_tap_chan: one channel's fine/coarse taps with saturation and settle timer
module phaser_tap_chan
  import phaser_out_mc_ctrl_pkg::*;
#(
  parameter int FINE_DELAY = 0,
  parameter int COARSE_DELAY = 0,
  parameter int SETTLE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic fine_en,
  input  logic fine_inc,
  input  logic coarse_en,
  input  logic coarse_inc,
  input  logic load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] tap,
  output logic busy,
  output logic fine_ovf,
  output logic coarse_ovf
);
  logic [FINE_W-1:0] fine_q, fine_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [3:0] settle_q, settle_d;
  logic fine_ovf_q, fine_ovf_d, coarse_ovf_q, coarse_ovf_d;
  logic act, fine_step, coarse_step, fine_sat, coarse_sat, fine_mv, coarse_mv;
  always_comb begin
    act = sel && settle_q == '0;
    fine_step = act && !load_en && fine_en;
    coarse_step = act && !load_en && coarse_en;
    fine_sat = fine_inc ? fine_q == FINE_MAX : fine_q == '0;
    coarse_sat = coarse_inc ? coarse_q == COARSE_MAX : coarse_q == '0;
    fine_mv = fine_step && !fine_sat;
    coarse_mv = coarse_step && !coarse_sat;
    fine_d = act && load_en ? load_val[FINE_W-1:0] :
             fine_mv ? (fine_inc ? fine_q + 1'b1 : fine_q - 1'b1) : fine_q;
    coarse_d = act && load_en ? load_val[CNT_W-1:FINE_W] :
               coarse_mv ? (coarse_inc ? coarse_q + 1'b1 : coarse_q - 1'b1) : coarse_q;
    fine_ovf_d = fine_step && fine_sat;
    coarse_ovf_d = coarse_step && coarse_sat;
    settle_d = act && (load_en || fine_mv || coarse_mv) ? 4'(SETTLE_CYC) :
               settle_q - {3'b0, settle_q != '0};
  end
  always_ff @(posedge clk)
    if (rst) begin
      fine_q <= FINE_W'(FINE_DELAY);
      coarse_q <= COARSE_W'(COARSE_DELAY);
      settle_q <= '0;
      fine_ovf_q <= 1'b0;
      coarse_ovf_q <= 1'b0;
    end else begin
      fine_q <= fine_d;
      coarse_q <= coarse_d;
      settle_q <= settle_d;
      fine_ovf_q <= fine_ovf_d;
      coarse_ovf_q <= coarse_ovf_d;
    end
  assign tap = {coarse_q, fine_q};
  assign busy = settle_q != '0;
  assign fine_ovf = fine_ovf_q;
  assign coarse_ovf = coarse_ovf_q;
endmodule

// File: rtl/phaser_out_mc_ctrl.sv
// phaser_out_mc_ctrl: multi-channel tap control with divided-clock enable and serializer reset
module phaser_out_mc_ctrl
  import phaser_out_mc_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CLKOUT_DIV = 4,
  parameter int FINE_DELAY = 0,
  parameter int COARSE_DELAY = 0,
  parameter int SETTLE_CYC = 4,
  parameter int RST_HOLD_DIV = 2,
  parameter string SYNC_IN_DIV_RST = "FALSE"
) (
  input logic SYSCLK,
  input logic RST,
  phaser_out_mc_ctrl_if.slave bus
);
  localparam int CW = chsel_w(NUM_CH);
  localparam bit SYNC_EN = SYNC_IN_DIV_RST == "TRUE";
  if (CLKOUT_DIV < DIV_MIN || CLKOUT_DIV > DIV_MAX) begin : g_bad_div
    $error("CLKOUT_DIV must be within 2..16");
  end
  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX || SETTLE_CYC < SETTLE_MIN ||
      SETTLE_CYC > SETTLE_MAX || RST_HOLD_DIV < HOLD_MIN || RST_HOLD_DIV > HOLD_MAX ||
      FINE_DELAY < 0 || FINE_DELAY > int'(FINE_MAX) || COARSE_DELAY < 0 ||
      COARSE_DELAY > int'(COARSE_MAX) ||
      (SYNC_IN_DIV_RST != "TRUE" && SYNC_IN_DIV_RST != "FALSE")) begin : g_bad_par
    $error("phaser_out_mc_ctrl parameter out of range");
  end
  logic [CNT_W-1:0] tap_a [2**CW];
  logic [CNT_W*NUM_CH-1:0] taps;
  logic [NUM_CH-1:0] busy, fine_ovf, coarse_ovf;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    phaser_tap_chan #(
      .FINE_DELAY(FINE_DELAY),
      .COARSE_DELAY(COARSE_DELAY),
      .SETTLE_CYC(SETTLE_CYC)
    ) u_chan (
      .clk(SYSCLK),
      .rst(RST),
      .sel(bus.CHSEL == CW'(i)),
      .fine_en(bus.FINEENABLE),
      .fine_inc(bus.FINEINC),
      .coarse_en(bus.COARSEENABLE),
      .coarse_inc(bus.COARSEINC),
      .load_en(bus.COUNTERLOADEN),
      .load_val(bus.COUNTERLOADVAL),
      .tap(tap_a[i]),
      .busy(busy[i]),
      .fine_ovf(fine_ovf[i]),
      .coarse_ovf(coarse_ovf[i])
    );
    assign taps[i*CNT_W +: CNT_W] = tap_a[i];
  end
  for (genvar i = NUM_CH; i < 2**CW; i++) begin : g_pad
    assign tap_a[i] = '0;
  end
  logic [3:0] div_q, div_d;
  logic [2:0] hold_q, hold_d;
  logic [CNT_W-1:0] rd_val_q, rd_val_d;
  logic run_q, run_d, sync_q, sync_d, orst_q, orst_d, rd_vld_q, rd_vld_d, oclk;
  // run_q masks the enable in the first cycle after reset so the hold count starts cleanly
  always_comb begin
    oclk = run_q && div_q == '0;
    run_d = 1'b1;
    sync_d = bus.SYNCIN;
    div_d = (SYNC_EN && bus.SYNCIN && !sync_q) || div_q == 4'(CLKOUT_DIV - 1) ? '0 : div_q + 1'b1;
    hold_d = hold_q + {2'b0, oclk && orst_q};
    orst_d = orst_q && !(oclk && hold_q == 3'(RST_HOLD_DIV - 1));
    rd_vld_d = bus.COUNTERREADEN;
    rd_val_d = bus.COUNTERREADEN ? tap_a[bus.CHSEL] : rd_val_q;
  end
  always_ff @(posedge SYSCLK)
    if (RST) begin
      div_q <= '0;
      hold_q <= '0;
      run_q <= 1'b0;
      sync_q <= 1'b0;
      orst_q <= 1'b1;
      rd_vld_q <= 1'b0;
      rd_val_q <= '0;
    end else begin
      div_q <= div_d;
      hold_q <= hold_d;
      run_q <= run_d;
      sync_q <= sync_d;
      orst_q <= orst_d;
      rd_vld_q <= rd_vld_d;
      rd_val_q <= rd_val_d;
    end
  assign bus.TAPS = taps;
  assign bus.BUSY = busy;
  assign bus.FINEOVERFLOW = fine_ovf;
  assign bus.COARSEOVERFLOW = coarse_ovf;
  assign bus.COUNTERREADVAL = rd_val_q;
  assign bus.COUNTERREADVALID = rd_vld_q;
  assign bus.OCLKDIVEN = oclk;
  assign bus.OSERDESRST = orst_q;
endmodule

// File: tb/tb_phaser_out_mc_ctrl.sv
// tb_phaser_out_mc_ctrl: directed and randomized checks against a behavioural model
module tb_phaser_out_mc_ctrl;
  localparam int NCH = 4, DIV = 4, FDLY = 5, CDLY = 0, SETTLE = 4, HOLD = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  phaser_out_mc_ctrl_if #(.NUM_CH(NCH)) bus ();
  phaser_out_mc_ctrl #(
    .NUM_CH(NCH),
    .CLKOUT_DIV(DIV),
    .FINE_DELAY(FDLY),
    .COARSE_DELAY(CDLY),
    .SETTLE_CYC(SETTLE),
    .RST_HOLD_DIV(HOLD),
    .SYNC_IN_DIV_RST("TRUE")
  ) dut (
    .SYSCLK(clk),
    .RST(rst),
    .bus(bus)
  );
  int vectors = 0, miscompares = 0;
  int fine_m [NCH], coarse_m [NCH], busy_until [NCH];
  int k, org, n_oclk, r;
  bit sync_prev, rd_vld_m, chk_on = 0;
  logic [NCH-1:0] fovf_m, covf_m;
  logic [8:0] rd_val_m;
  function automatic bit oclk_m();
    return k > 0 && (k - org) % DIV == 0;
  endfunction
  function automatic logic [8:0] tap_m(int ch);
    return 9'(coarse_m[ch] * 64 + fine_m[ch]);
  endfunction
  function automatic logic [9*NCH-1:0] taps_m();
    logic [9*NCH-1:0] t;
    for (int c = 0; c < NCH; c++) t[c*9 +: 9] = tap_m(c);
    return t;
  endfunction
  function automatic logic [NCH-1:0] busy_m();
    logic [NCH-1:0] b;
    for (int c = 0; c < NCH; c++) b[c] = k < busy_until[c];
    return b;
  endfunction
  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic model_step();
    int ch;
    bit rise, moved;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        fine_m[c] = FDLY;
        coarse_m[c] = CDLY;
        busy_until[c] = 0;
      end
      k = 0; org = 0; n_oclk = 0; sync_prev = 0;
      rd_vld_m = 0; rd_val_m = '0; fovf_m = '0; covf_m = '0;
    end else begin
      ch = int'(bus.CHSEL);
      rd_vld_m = bus.COUNTERREADEN;
      if (bus.COUNTERREADEN) rd_val_m = tap_m(ch);
      if (oclk_m()) n_oclk++;
      rise = bus.SYNCIN && !sync_prev;
      sync_prev = bus.SYNCIN;
      fovf_m = '0; covf_m = '0;
      if (k >= busy_until[ch]) begin
        if (bus.COUNTERLOADEN) begin
          fine_m[ch] = int'(bus.COUNTERLOADVAL) % 64;
          coarse_m[ch] = int'(bus.COUNTERLOADVAL) / 64;
          busy_until[ch] = k + 1 + SETTLE;
        end else begin
          moved = 0;
          if (bus.FINEENABLE) begin
            if (bus.FINEINC ? fine_m[ch] == 63 : fine_m[ch] == 0) fovf_m[ch] = 1'b1;
            else begin fine_m[ch] += bus.FINEINC ? 1 : -1; moved = 1; end
          end
          if (bus.COARSEENABLE) begin
            if (bus.COARSEINC ? coarse_m[ch] == 7 : coarse_m[ch] == 0) covf_m[ch] = 1'b1;
            else begin coarse_m[ch] += bus.COARSEINC ? 1 : -1; moved = 1; end
          end
          if (moved) busy_until[ch] = k + 1 + SETTLE;
        end
      end
      k++;
      if (rise) org = k;
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic idle();
    bus.FINEENABLE = 0; bus.COARSEENABLE = 0; bus.COUNTERLOADEN = 0; bus.COUNTERREADEN = 0;
  endtask
  always @(negedge clk)
    if (chk_on) begin
      cmp("taps", bus.TAPS, taps_m());
      cmp("busy", bus.BUSY, busy_m());
      cmp("fine_ovf", bus.FINEOVERFLOW, fovf_m);
      cmp("coarse_ovf", bus.COARSEOVERFLOW, covf_m);
      cmp("read_valid", bus.COUNTERREADVALID, rd_vld_m);
      cmp("read_val", bus.COUNTERREADVAL, rd_val_m);
      cmp("oclkdiven", bus.OCLKDIVEN, oclk_m());
      cmp("oserdesrst", bus.OSERDESRST, n_oclk < HOLD);
    end
  initial begin
    bus.SYNCIN = 0; bus.CHSEL = '0; bus.FINEINC = 0; bus.COARSEINC = 0; bus.COUNTERLOADVAL = '0;
    idle();
    tick();
    chk_on = 1;
    repeat (2) tick();
    rst = 0;
    cmp("reset_tap0", bus.TAPS[8:0], 9'h005);
    cmp("reset_busy", bus.BUSY, 0);
    cmp("reset_orst", bus.OSERDESRST, 1);
    cmp("reset_oclk", bus.OCLKDIVEN, 0);
    repeat (8) tick();
    cmp("oclk_c8", bus.OCLKDIVEN, 1);
    cmp("orst_c8", bus.OSERDESRST, 1);
    tick();
    cmp("orst_c9", bus.OSERDESRST, 0);
    bus.CHSEL = 2'd1; bus.COUNTERLOADEN = 1; bus.COUNTERLOADVAL = 9'h000;
    tick(); idle(); repeat (4) tick();
    for (int p = 0; p < 3; p++) begin
      bus.FINEENABLE = 1; bus.FINEINC = 1;
      tick(); idle();
      cmp("step_busy_on", bus.BUSY[1], 1);
      repeat (3) tick();
      cmp("step_busy_hold", bus.BUSY[1], 1);
      tick();
      cmp("step_busy_off", bus.BUSY[1], 0);
    end
    cmp("ch1_fine3", bus.TAPS[17:9], 9'h003);
    bus.FINEENABLE = 1; tick(); idle(); tick();
    bus.FINEENABLE = 1; tick(); idle();
    cmp("busy_ignore", bus.TAPS[17:9], 9'h004);
    repeat (3) tick();
    bus.CHSEL = 2'd2; bus.COUNTERLOADEN = 1; bus.COUNTERLOADVAL = 9'h1FF;
    tick(); idle(); repeat (4) tick();
    bus.FINEENABLE = 1; bus.FINEINC = 1;
    tick(); idle();
    cmp("sat_tap", bus.TAPS[26:18], 9'h1FF);
    cmp("sat_ovf", bus.FINEOVERFLOW[2], 1);
    cmp("sat_busy", bus.BUSY[2], 0);
    tick();
    cmp("sat_ovf_end", bus.FINEOVERFLOW[2], 0);
    bus.CHSEL = 2'd0; bus.COUNTERLOADEN = 1; bus.COUNTERLOADVAL = 9'h040; bus.FINEENABLE = 1;
    tick(); idle();
    cmp("load_wins", bus.TAPS[8:0], 9'h040);
    repeat (4) tick();
    bus.CHSEL = 2'd3; bus.COUNTERLOADEN = 1; bus.COUNTERLOADVAL = 9'h0A3;
    tick(); idle(); repeat (4) tick();
    bus.COARSEENABLE = 1; bus.COARSEINC = 1; bus.COUNTERREADEN = 1;
    tick(); idle();
    cmp("read_pre", bus.COUNTERREADVAL, 9'h0A3);
    cmp("read_vld", bus.COUNTERREADVALID, 1);
    cmp("read_tap_post", bus.TAPS[35:27], 9'h0E3);
    tick();
    cmp("read_vld_end", bus.COUNTERREADVALID, 0);
    cmp("read_hold", bus.COUNTERREADVAL, 9'h0A3);
    for (int w = 0; w < 8 && !bus.OCLKDIVEN; w++) tick();
    cmp("oclk_found", bus.OCLKDIVEN, 1);
    repeat (2) tick();
    bus.SYNCIN = 1;
    tick();
    cmp("sync_realign", bus.OCLKDIVEN, 1);
    repeat (4) tick();
    cmp("sync_period", bus.OCLKDIVEN, 1);
    repeat (5) tick();
    bus.SYNCIN = 0;
    for (int n = 0; n < 3000; n++) begin
      bus.CHSEL = 2'($urandom_range(0, NCH - 1));
      bus.FINEENABLE = $urandom_range(0, 3) == 0;
      bus.FINEINC = 1'($urandom_range(0, 1));
      bus.COARSEENABLE = $urandom_range(0, 3) == 0;
      bus.COARSEINC = 1'($urandom_range(0, 1));
      bus.COUNTERLOADEN = $urandom_range(0, 11) == 0;
      r = $urandom_range(0, 3);
      bus.COUNTERLOADVAL = r == 0 ? 9'h1FF : r == 1 ? 9'h000 : 9'($urandom);
      bus.COUNTERREADEN = $urandom_range(0, 4) == 0;
      bus.SYNCIN = $urandom_range(0, 15) == 0 ? ~bus.SYNCIN : bus.SYNCIN;
      rst = $urandom_range(0, 399) == 0;
      tick();
    end
    rst = 0; idle();
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
